// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit format, route indices and the XY route function.
package noc_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      HEAD = 2'b10,
      BODY = 2'b00,
      TAIL = 2'b01
   } flit_type_e;

   localparam int TYPE_MSB  = 31;
   localparam int TYPE_LSB  = 30;
   localparam int DST_Y_MSB = 23;
   localparam int DST_Y_LSB = 21;
   localparam int DST_X_MSB = 20;
   localparam int DST_X_LSB = 18;

   localparam int LOC = 4;
   localparam int E   = 3;
   localparam int W   = 2;
   localparam int S   = 1;
   localparam int N   = 0;

   // The unused code 2'b11 decodes as BODY so it never opens or closes a packet.
   function automatic flit_type_e flit_type(input logic [1:0] code);
      case (code)
         2'b10:   return HEAD;
         2'b01:   return TAIL;
         default: return BODY;
      endcase
   endfunction

   // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
   function automatic logic [4:0] route(input logic [2:0] dst_x, input logic [2:0] dst_y,
                                        input logic [2:0] here_x, input logic [2:0] here_y);
      logic [4:0] r;
      r = '0;
      if (dst_x > here_x)      r[E]   = 1'b1;
      else if (dst_x < here_x) r[W]   = 1'b1;
      else if (dst_y > here_y) r[S]   = 1'b1;
      else if (dst_y < here_y) r[N]   = 1'b1;
      else                     r[LOC] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer: power-of-2 circular FIFO with first-word-fall-through read.
// A push while full is dropped unless a pop happens on the same edge.
module flit_fifo #(
   parameter int DEPTH      = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [WORD_WIDTH-1:0]   wdata,
   input  logic                    pop,
   output logic [WORD_WIDTH-1:0]   rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/input_unit.sv
// Router input port: buffers upstream flits, computes the XY route from the
// packet head, requests the crossbar and streams the packet out.
//
// state | meaning
// IDLE  | waiting for a HEAD at the FIFO head; stray non-HEAD flits are dropped
// REQ   | route latched; req raised one cycle later, then wait for grant
// XFER  | granted; pop one flit per cycle while stop_in is low, until TAIL
module input_unit #(
   parameter int         WORD_WIDTH = 32,
   parameter int         DEPTH      = 8,
   parameter logic [2:0] ROUTER_X   = 3'd0,
   parameter logic [2:0] ROUTER_Y   = 3'd0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] DataIn,
   input  logic                  DataVoidIn,
   output logic                  stop_out,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  void_out,
   output logic [4:0]            req,
   input  logic                  grant,
   input  logic                  stop_in,
   output logic                  overflow_err,
   output logic                  framing_err
);

   import noc_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] STOP_LEVEL = CW'(DEPTH - 3);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

   state_e                state, state_nxt;
   logic [WORD_WIDTH-1:0] head;
   logic                  full, empty, push, push_ok, pop;
   logic [CW-1:0]         count, count_nxt;
   logic [4:0]            route_q, route_nxt, req_nxt;
   logic [WORD_WIDTH-1:0] data_nxt;
   logic                  void_nxt, first_q, first_nxt, frame_set;
   flit_type_e            head_type;

   assign push      = !DataVoidIn;
   assign push_ok   = push && (!full || pop);
   assign head_type = flit_type(head[TYPE_MSB:TYPE_LSB]);

   flit_fifo #(.DEPTH(DEPTH), .WORD_WIDTH(WORD_WIDTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (DataIn),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Next-state, pop decision and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      route_nxt = route_q;
      req_nxt   = req;
      data_nxt  = '0;
      void_nxt  = 1'b1;
      first_nxt = first_q;
      pop       = 1'b0;
      frame_set = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (head_type == HEAD) begin
                  route_nxt = route(head[DST_X_MSB:DST_X_LSB], head[DST_Y_MSB:DST_Y_LSB],
                                    ROUTER_X, ROUTER_Y);
                  state_nxt = REQ;
               end else begin
                  pop       = 1'b1;
                  frame_set = 1'b1;
               end
            end
         end
         REQ: begin
            // grant only counts once req is actually visible to the arbiter
            if (req == '0) begin
               req_nxt = route_q;
            end else if (grant) begin
               state_nxt = XFER;
               first_nxt = 1'b1;
            end
         end
         XFER: begin
            if (!empty && !stop_in) begin
               pop       = 1'b1;
               data_nxt  = head;
               void_nxt  = 1'b0;
               first_nxt = 1'b0;
               if (head_type == TAIL) begin
                  state_nxt = IDLE;
                  req_nxt   = '0;
               end else if (head_type == HEAD && !first_q) begin
                  frame_set = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy after this edge, used to raise backpressure with 3 slots of slack.
   always_comb begin
      case ({push_ok, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         route_q      <= '0;
         req          <= '0;
         data_out     <= '0;
         void_out     <= 1'b1;
         first_q      <= 1'b0;
         stop_out     <= 1'b1;
         overflow_err <= 1'b0;
         framing_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         route_q      <= route_nxt;
         req          <= req_nxt;
         data_out     <= data_nxt;
         void_out     <= void_nxt;
         first_q      <= first_nxt;
         stop_out     <= (count_nxt >= STOP_LEVEL);
         overflow_err <= overflow_err | (push && full && !pop);
         framing_err  <= framing_err | frame_set;
      end
   end

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit on router (1,1), DEPTH 8.
module tb_input_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] DataIn = '0;
   logic        DataVoidIn = 1'b1;
   logic        stop_out;
   logic [31:0] data_out;
   logic        void_out;
   logic [4:0]  req;
   logic        grant = 1'b1;
   logic        stop_in = 1'b0;
   logic        overflow_err;
   logic        framing_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [4:0] R_LOC = 5'b10000;
   localparam logic [4:0] R_E   = 5'b01000;
   localparam logic [4:0] R_W   = 5'b00100;
   localparam logic [4:0] R_S   = 5'b00010;
   localparam logic [4:0] R_N   = 5'b00001;

   input_unit #(.WORD_WIDTH(32), .DEPTH(8), .ROUTER_X(3'd1), .ROUTER_Y(3'd1)) dut (
      .clk          (clk),
      .reset        (reset),
      .DataIn       (DataIn),
      .DataVoidIn   (DataVoidIn),
      .stop_out     (stop_out),
      .data_out     (data_out),
      .void_out     (void_out),
      .req          (req),
      .grant        (grant),
      .stop_in      (stop_in),
      .overflow_err (overflow_err),
      .framing_err  (framing_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         dx;
      int         dy;
      logic [4:0] exp_req;
   } route_vec_t;

   route_vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      DataIn     = w;
      DataVoidIn = 1'b0;
      tick();
      DataVoidIn = 1'b1;
   endtask

   task automatic do_reset();
      DataVoidIn = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Wait (bounded) for the next valid output flit and compare it.
   task automatic expect_out(input string name, input logic [31:0] exp);
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!void_out) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) check(name, data_out, exp);
      else check({name, " (timeout)"}, 32'hDEAD_DEAD, exp);
   endtask

   task automatic wait_req(output logic [4:0] got);
      for (int i = 0; i < 10; i++) begin
         if (req != '0) break;
         tick();
      end
      got = req;
   endtask

   function automatic logic [31:0] mk_head(input int dx, input int dy, input logic [4:0] tag);
      logic [31:0] w;
      w = '0;
      w[31:30] = 2'b10;
      w[23:21] = dy[2:0];
      w[20:18] = dx[2:0];
      w[15:8]  = 8'hA5;
      w[4:0]   = tag;
      return w;
   endfunction

   function automatic logic [31:0] mk_body(input logic [7:0] p);
      return {2'b00, 14'h0, p, p};
   endfunction

   function automatic logic [31:0] mk_tail(input logic [7:0] p);
      return {2'b01, 14'h0, p, ~p};
   endfunction

   initial begin
      logic [31:0] pkt [9];
      logic [4:0]  got;
      logic [31:0] h, b, t;
      bit          leaked;

      vecs[0] = '{1, 0, R_N};
      vecs[1] = '{1, 3, R_S};
      vecs[2] = '{1, 1, R_LOC};
      vecs[3] = '{2, 1, R_E};
      vecs[4] = '{0, 1, R_W};
      vecs[5] = '{0, 5, R_W};
      vecs[6] = '{7, 0, R_E};
      vecs[7] = '{1, 7, R_S};

      // reset state
      #1 reset = 1'b1;
      tick();
      check("rst void_out", void_out, 1);
      check("rst data_out", data_out, 0);
      check("rst req", req, 0);
      check("rst stop_out", stop_out, 1);
      check("rst overflow_err", overflow_err, 0);
      check("rst framing_err", framing_err, 0);
      reset = 1'b0;
      tick();
      check("stop_out release", stop_out, 0);

      // 3-flit packet to East, exact latency
      h = mk_head(2, 1, 5'h1F);
      b = mk_body(8'h3C);
      t = mk_tail(8'h81);
      send(h);
      check("lat req@N", req, 0);
      send(b);
      check("lat req@N+1", req, 0);
      send(t);
      check("lat req@N+2", req, R_E);
      tick();
      check("lat void@N+3", void_out, 1);
      tick();
      check("lat head@N+4", data_out, h);
      check("lat void@N+4", void_out, 0);
      check("lat req held", req, R_E);
      tick();
      check("lat body@N+5", data_out, b);
      tick();
      check("lat tail@N+6", data_out, t);
      check("req clear after tail", req, 0);
      tick();
      check("void after tail", void_out, 1);

      // route table
      for (int i = 0; i < 8; i++) begin
         h = mk_head(vecs[i].dx, vecs[i].dy, 5'(i + 3));
         t = mk_tail(8'(i));
         send(h);
         send(t);
         wait_req(got);
         check($sformatf("route[%0d] req", i), got, vecs[i].exp_req);
         expect_out($sformatf("route[%0d] head", i), h);
         expect_out($sformatf("route[%0d] tail", i), t);
         check($sformatf("route[%0d] req off", i), req, 0);
      end
      check("route framing_err", framing_err, 0);

      // backpressure: 8 flits with stop_in held, then simultaneous push/pop at full
      do_reset();
      stop_in = 1'b1;
      pkt[0] = mk_head(2, 1, 5'h05);
      for (int k = 1; k < 7; k++) pkt[k] = mk_body(8'(8'h10 + k));
      pkt[7] = mk_tail(8'h77);
      for (int k = 0; k < 8; k++) begin
         send(pkt[k]);
         check($sformatf("stop_out after %0d", k + 1), stop_out, ((k + 1) >= 5) ? 1 : 0);
      end
      check("bp overflow_err", overflow_err, 0);
      stop_in = 1'b0;
      h = mk_head(0, 1, 5'h0A);
      send(h);
      check("full push+pop overflow", overflow_err, 0);
      check("bp flit0", data_out, pkt[0]);
      check("bp stop_out full", stop_out, 1);
      for (int k = 1; k < 8; k++) expect_out($sformatf("bp flit%0d", k), pkt[k]);
      t = mk_tail(8'h5A);
      send(t);
      wait_req(got);
      check("bp next req", got, R_W);
      expect_out("bp next head", h);
      expect_out("bp next tail", t);
      check("bp stop_out low", stop_out, 0);
      check("bp framing_err", framing_err, 0);

      // overflow: 9th flit dropped
      do_reset();
      stop_in = 1'b1;
      for (int k = 0; k < 8; k++) send(pkt[k]);
      check("ovf before 9th", overflow_err, 0);
      send(mk_body(8'hEE));
      check("ovf after 9th", overflow_err, 1);
      stop_in = 1'b0;
      for (int k = 0; k < 8; k++) expect_out($sformatf("ovf flit%0d", k), pkt[k]);
      for (int k = 0; k < 4; k++) tick();
      check("ovf 9th not stored", framing_err, 0);
      check("ovf void idle", void_out, 1);
      check("ovf sticky", overflow_err, 1);

      // stray BODY in IDLE
      do_reset();
      send(mk_body(8'h42));
      leaked = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (!void_out) leaked = 1'b1;
      end
      check("stray body void", leaked, 0);
      check("stray body framing", framing_err, 1);
      check("stray body req", req, 0);
      h = mk_head(1, 0, 5'h11);
      t = mk_tail(8'h99);
      send(h);
      send(t);
      wait_req(got);
      check("after stray req", got, R_N);
      expect_out("after stray head", h);
      expect_out("after stray tail", t);

      // HEAD inside a packet: forwarded, flagged, packet continues
      do_reset();
      h = mk_head(2, 1, 5'h01);
      b = mk_head(0, 0, 5'h02);
      t = mk_tail(8'h24);
      send(h);
      send(b);
      send(t);
      expect_out("dup head1", h);
      check("dup framing before", framing_err, 0);
      expect_out("dup head2", b);
      check("dup framing after", framing_err, 1);
      expect_out("dup tail", t);
      check("dup req off", req, 0);

      // reset in the middle of a packet
      do_reset();
      h = mk_head(1, 0, 5'h07);
      b = mk_body(8'h61);
      t = mk_tail(8'h62);
      send(h);
      send(b);
      send(t);
      expect_out("mid head", h);
      expect_out("mid body", b);
      reset = 1'b1;
      #1;
      check("mid rst void", void_out, 1);
      check("mid rst req", req, 0);
      check("mid rst data", data_out, 0);
      tick();
      tick();
      reset = 1'b0;
      leaked = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (!void_out || req != '0) leaked = 1'b1;
      end
      check("mid no tail", leaked, 0);
      h = mk_head(0, 1, 5'h13);
      t = mk_tail(8'h31);
      send(h);
      send(t);
      wait_req(got);
      check("post rst req", got, R_W);
      expect_out("post rst head", h);
      expect_out("post rst tail", t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/input_unit.md
INPUT_UNIT -- requirements
Module: input_unit

Interface
REQ-001 Parameters: WORD_WIDTH = 32, flit width; DEPTH = 8, FIFO entries (power of 2, >= 4); ROUTER_X = 0, local X coordinate (3 bits); ROUTER_Y = 0, local Y coordinate (3 bits).
REQ-002 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- DataIn  in  WORD_WIDTH  upstream flit.
- DataVoidIn  in  1  1 = no flit this cycle.
- stop_out  out  1  backpressure to upstream.
- data_out  out  WORD_WIDTH  forwarded flit.
- void_out  out  1  1 = data_out invalid.
- req  out  5  one-hot output request {Loc,E,W,S,N}.
- grant  in  1  crossbar grant for req.
- stop_in  in  1  downstream backpressure.
- overflow_err  out  1  sticky error.
- framing_err  out  1  sticky error.

Function
REQ-003 Flit type is bits [31:30]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL; 2'b11 is illegal and is treated as BODY.
REQ-004 HEAD fields: [23:21] dstY, [20:18] dstX; bits [4:0] are ignored on input and forwarded unchanged.
REQ-005 Write rule: every cycle with DataVoidIn==0, DataIn is written to the FIFO regardless of stop_out.
REQ-006 Overflow: a write while the FIFO is full drops the flit and sets overflow_err, which holds until reset.
REQ-007 stop_out is registered and is 1 when free slots after the current edge are <= 3; the upstream may send up to 3 flits after stop_out rises.
REQ-008 Route is computed as XY routing from the FIFO-head HEAD flit, in priority order:
- E if dstX>ROUTER_X.
- W if dstX<ROUTER_X.
- S if dstY>ROUTER_Y.
- N if dstY<ROUTER_Y.
- Loc otherwise.
REQ-009 FSM has three states: IDLE, REQ, XFER.
REQ-010 IDLE, FIFO head is HEAD: latch the route, assert req next cycle, go to REQ.
REQ-011 IDLE, FIFO head is non-HEAD: pop and discard the flit and set framing_err (sticky).
REQ-012 IDLE, FIFO empty: remain in IDLE with req=0.
REQ-013 REQ: hold req constant; when grant==1, go to XFER at the next edge. grant is sampled only in REQ.
REQ-014 XFER, FIFO non-empty and stop_in==0: pop one flit; data_out gets the flit and void_out=0 at the next edge.
REQ-015 XFER, otherwise: void_out=1 and data_out=0 at the next edge.
REQ-016 The first flit popped in XFER is the HEAD.
REQ-017 When the popped flit is TAIL, the next edge sets state=IDLE and req=0 while data_out carries the TAIL.
REQ-018 A HEAD popped in XFER before a TAIL is forwarded, sets framing_err, and the packet continues.
REQ-019 Latency: a HEAD written at edge N (FIFO empty, IDLE) gives req at N+2. With grant at N+2, XFER begins at N+3 and the HEAD is on data_out at N+4.
REQ-020 Simultaneous push and pop is allowed in any occupancy, including full: occupancy is unchanged and overflow_err is not set.
REQ-021 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.

Reset
REQ-022 Reset (async assert, sync release) sets:
- state=IDLE, FIFO empty, req=0.
- void_out=1, data_out=0.
- stop_out=1, which releases on the first edge after deassertion.
- overflow_err=0, framing_err=0.
REQ-023 Reset mid-packet discards all buffered flits, and no partial packet is forwarded after release.

Structure
REQ-024 Package noc_pkg holds:
- WORD_WIDTH.
- flit_type_e {HEAD, BODY, TAIL}.
- field bit-position constants.
- route index constants LOC/E/W/S/N = 4..0.
- the route function.
REQ-025 The storage is one sub-module, flit_fifo (DEPTH, WORD_WIDTH; push, pop, full, empty, count). The FSM and route logic live in input_unit.

Verification
REQ-026 ROUTER_X=1, ROUTER_Y=1; 3-flit packet HEAD(dstY=1, dstX=2), BODY, TAIL; grant tied 1, stop_in=0 -> req=5'b01000 (E), flits out in order on 3 consecutive cycles, req=0 after TAIL.
REQ-027 Same router; HEAD with dstX=1, dstY=0, then dstY=3, then dstY=1 -> req=N (5'b00001), S (5'b00010), Loc (5'b10000).
REQ-028 stop_in=1, 8 back-to-back flits -> stop_out=1 once occupancy reaches 5; 3 more flits accepted; overflow_err stays 0; all 8 forwarded intact after stop_in=0.
REQ-029 Same as REQ-028 with upstream ignoring stop_out (9 flits) -> 9th flit dropped, overflow_err=1, first 8 forwarded.
REQ-030 BODY flit arriving in IDLE -> discarded, framing_err=1, void_out stays 1; the following valid packet is forwarded normally.
REQ-031 Reset asserted after HEAD+BODY forwarded -> void_out=1, req=0 immediately; no TAIL emitted; the next packet routes correctly.
